// File: rtl/dimc_mac_array_param.sv
// Parametrised digital in-memory-compute macro: kernel SRAM with masked word
// writes, feature register, and a pipelined 1/2/4-bit saturating dot-product MAC.
module dimc_mac_array_param #(
    parameter  int ROWS  = 32,
    parameter  int SEC   = 4,
    parameter  int W     = 256,
    parameter  int ACC_W = 24,
    parameter  int LAT   = 4,
    localparam int AW    = $clog2(ROWS * SEC),
    localparam int FAW   = (SEC > 1) ? $clog2(SEC) : 1
) (
    input  logic             RCK,
    input  logic             RESETn,
    input  logic [AW-1:0]    WA,
    input  logic [W-1:0]     D,
    input  logic [W-1:0]     M,
    input  logic             WCSN,
    input  logic             WEN,
    input  logic [AW-1:0]    RA,
    input  logic             RCSN,
    input  logic             COMPE,
    input  logic [1:0]       MODE,
    input  logic [FAW-1:0]   FA,
    input  logic [W-1:0]     FD,
    input  logic             FCSN,
    input  logic [ACC_W-1:0] ADDIN,
    input  logic [ACC_W-1:0] THR,
    output logic [W-1:0]     Q,
    output logic [ACC_W-1:0] PSOUT,
    output logic             SOUT,
    output logic             OVF,
    output logic             READYN
);
    localparam int RW    = $clog2(ROWS);
    localparam int SUM_W = ACC_W + $clog2(SEC * W) + 8;

    typedef struct packed {
        logic             v;
        logic [ACC_W-1:0] ps;
        logic             so;
        logic             ov;
    } pipe_t;

    logic [W-1:0]     mem  [ROWS*SEC];
    logic [W-1:0]     feat [SEC];
    pipe_t            pipe [LAT];

    logic [RW-1:0]    ra_row;
    logic [AW-1:0]    kidx;
    logic [W-1:0]     kw;
    logic [W-1:0]     fw;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] full;
    logic [ACC_W-1:0] ps_c;
    logic             ovf_c;
    logic             so_c;
    logic             mac_en;
    logic             rd_en;

    assign ra_row = RA[AW-1 -: RW];
    assign mac_en = !RCSN && COMPE && (MODE != 2'b11);
    assign rd_en  = !RCSN && !COMPE;

    // Kernel array is not reset; reads elsewhere see the pre-edge contents,
    // which gives read-before-write on same-edge collisions.
    always_ff @(posedge RCK) begin
        if (!WCSN && !WEN) begin
            mem[WA] <= (mem[WA] & ~M) | (D & M);
        end
    end

    always_comb begin
        sum  = '0;
        kidx = '0;
        kw   = '0;
        fw   = '0;
        for (int s = 0; s < SEC; s++) begin
            kidx = AW'(int'(ra_row) * SEC + s);
            kw   = mem[kidx];
            fw   = feat[s];
            case (MODE)
                2'b00: begin
                    for (int j = 0; j < W; j++) begin
                        sum = sum + SUM_W'(kw[j] & fw[j]);
                    end
                end
                2'b01: begin
                    for (int j = 0; j < W / 2; j++) begin
                        sum = sum + SUM_W'(kw[2*j +: 2]) * SUM_W'(fw[2*j +: 2]);
                    end
                end
                default: begin
                    for (int j = 0; j < W / 4; j++) begin
                        sum = sum + SUM_W'(kw[4*j +: 4]) * SUM_W'(fw[4*j +: 4]);
                    end
                end
            endcase
        end
        full  = sum + SUM_W'(ADDIN);
        ovf_c = |full[SUM_W-1:ACC_W];
        ps_c  = ovf_c ? '1 : full[ACC_W-1:0];
        so_c  = (ps_c >= THR);
    end

    // READYN is a one-cycle active-low valid with no ready: the consumer must
    // capture PSOUT/SOUT/OVF during that cycle, they hold otherwise.
    always_ff @(posedge RCK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
            for (int s = 0; s < SEC; s++) begin
                feat[s] <= '0;
            end
            Q      <= '0;
            PSOUT  <= '0;
            SOUT   <= 1'b0;
            OVF    <= 1'b0;
            READYN <= 1'b1;
        end else begin
            if (!FCSN && (int'(FA) < SEC)) begin
                feat[FA] <= FD;
            end
            if (rd_en) begin
                Q <= mem[RA];
            end
            pipe[0] <= '{v: mac_en, ps: ps_c, so: so_c, ov: ovf_c};
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            READYN <= ~pipe[LAT-1].v;
            if (pipe[LAT-1].v) begin
                PSOUT <= pipe[LAT-1].ps;
                SOUT  <= pipe[LAT-1].so;
                OVF   <= pipe[LAT-1].ov;
            end
        end
    end
endmodule

// File: tb/tb_dimc_mac_array_param.sv
// Bench for dimc_mac_array_param: directed vector table, hand sequences for
// pipelining/hazard/reset, and random traffic against an array-based model.
module tb_dimc_mac_array_param;
    localparam int ROWS  = 32;
    localparam int SEC   = 4;
    localparam int W     = 256;
    localparam int ACC_W = 24;
    localparam int LAT   = 4;
    localparam int AW    = $clog2(ROWS * SEC);
    localparam int FAW   = (SEC > 1) ? $clog2(SEC) : 1;
    localparam int EW    = ACC_W + 2;

    logic             RCK = 1'b0;
    logic             RESETn;
    logic [AW-1:0]    WA, RA;
    logic [W-1:0]     D, M, FD;
    logic             WCSN, WEN, RCSN, COMPE, FCSN;
    logic [1:0]       MODE;
    logic [FAW-1:0]   FA;
    logic [ACC_W-1:0] ADDIN, THR;
    logic [W-1:0]     Q;
    logic [ACC_W-1:0] PSOUT;
    logic             SOUT, OVF, READYN;

    dimc_mac_array_param #(.ROWS(ROWS), .SEC(SEC), .W(W), .ACC_W(ACC_W), .LAT(LAT)) dut (
        .RCK(RCK), .RESETn(RESETn), .WA(WA), .D(D), .M(M), .WCSN(WCSN), .WEN(WEN),
        .RA(RA), .RCSN(RCSN), .COMPE(COMPE), .MODE(MODE), .FA(FA), .FD(FD),
        .FCSN(FCSN), .ADDIN(ADDIN), .THR(THR), .Q(Q), .PSOUT(PSOUT), .SOUT(SOUT),
        .OVF(OVF), .READYN(READYN)
    );

    // clock / cycle counter
    always #5 RCK = ~RCK;
    int cyc = 0;
    always @(posedge RCK) cyc++;

    // reference state and scoreboard
    logic [W-1:0]  kern   [ROWS*SEC];
    logic [W-1:0]  feat_m [SEC];
    logic [EW-1:0] exp_q[$];
    int            exp_t[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    bit            tbl_on = 0;
    logic [EW-1:0] tbl_exp;

    typedef struct {
        logic [1:0]       mode;
        logic [ACC_W-1:0] addin;
        logic [ACC_W-1:0] thr;
        logic [ACC_W-1:0] ps;
        logic             so;
        logic             ov;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // dot product from element definitions: element j = (word >> j*P) mod 2^P
    function automatic logic [EW-1:0] model_mac(int row, logic [1:0] mode,
                                                 logic [ACC_W-1:0] addin, logic [ACC_W-1:0] thr);
        int           p;
        longint       acc, maxv;
        logic [W-1:0] kt, ft;
        logic         so, ov;
        p    = 1 << mode;
        acc  = 0;
        maxv = (longint'(1) << ACC_W) - 1;
        for (int s = 0; s < SEC; s++) begin
            for (int j = 0; j < W / p; j++) begin
                kt  = kern[row * SEC + s] >> (j * p);
                ft  = feat_m[s] >> (j * p);
                acc = acc + longint'((int'(kt[3:0]) & ((1 << p) - 1)) *
                                     (int'(ft[3:0]) & ((1 << p) - 1)));
            end
        end
        acc = acc + longint'(addin);
        ov  = (acc > maxv);
        if (ov) acc = maxv;
        so  = (acc >= longint'(thr));
        return {ACC_W'(acc), so, ov};
    endfunction

    task automatic idle();
        WCSN = 1'b1; WEN = 1'b1; RCSN = 1'b1; COMPE = 1'b0; FCSN = 1'b1;
        MODE = 2'b00; WA = '0; RA = '0; FA = '0; D = '0; M = '0; FD = '0;
        ADDIN = '0; THR = '0;
    endtask

    task automatic fail_line(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_fail++;
        $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    endtask

    // apply the currently driven inputs for one edge; model sees pre-edge state
    task automatic tick();
        logic [W-1:0] q_new;
        bit           rd;
        rd    = RESETn && !RCSN && !COMPE;
        q_new = kern[RA];
        if (RESETn && !RCSN && COMPE && MODE != 2'b11) begin
            exp_q.push_back(tbl_on ? tbl_exp : model_mac(int'(RA) / SEC, MODE, ADDIN, THR));
            exp_t.push_back(cyc + 1 + LAT);
        end
        if (RESETn && !WCSN && !WEN) kern[WA] = (kern[WA] & ~M) | (D & M);
        if (RESETn && !FCSN) feat_m[FA] = FD;
        @(posedge RCK);
        #1;
        if (rd) begin
            n_cmp++;
            if (Q !== q_new) fail_line("q_read", Q, q_new);
        end
        idle();
    endtask

    task automatic write_word(int a, logic [W-1:0] d, logic [W-1:0] m);
        WCSN = 1'b0; WEN = 1'b0; WA = AW'(a); D = d; M = m;
    endtask

    task automatic mac_req(int row, logic [1:0] mode, logic [ACC_W-1:0] addin, logic [ACC_W-1:0] thr);
        RCSN = 1'b0; COMPE = 1'b1; RA = AW'(row * SEC); MODE = mode; ADDIN = addin; THR = thr;
    endtask

    // result monitor: every cycle READYN must match the scoreboard's schedule
    logic [EW-1:0] mon_e;
    int            mon_t;
    always @(negedge RCK) begin
        if (RESETn) begin
            if (exp_t.size() > 0 && exp_t[0] <= cyc) begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t.pop_front();
                n_cmp++;
                if (READYN !== 1'b0) begin
                    n_fail++;
                    $display("FAIL readyn_pulse at cycle %0d (due %0d): got %b expected 0", cyc, mon_t, READYN);
                end else begin
                    n_cmp++;
                    if ({PSOUT, SOUT, OVF} !== mon_e) begin
                        n_fail++;
                        $display("FAIL mac_result at cycle %0d: got ps=%h s=%b o=%b expected ps=%h s=%b o=%b",
                                 cyc, PSOUT, SOUT, OVF, mon_e[EW-1:2], mon_e[1], mon_e[0]);
                    end
                end
            end else begin
                n_cmp++;
                if (READYN !== 1'b1) begin
                    n_fail++;
                    $display("FAIL readyn_idle at cycle %0d: got %b expected 1", cyc, READYN);
                end
            end
        end
    end

    task automatic check_reset_outputs(string name);
        n_cmp++;
        if ({Q, PSOUT, SOUT, OVF, READYN} !== {{W{1'b0}}, {ACC_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s: got q=%h ps=%h s=%b o=%b rdyn=%b expected zeros with rdyn=1",
                     name, Q, PSOUT, SOUT, OVF, READYN);
        end
    endtask

    initial begin
        tbl[0] = '{2'b00, 24'h0,      24'h0,      24'd1024,   1'b1, 1'b0};
        tbl[1] = '{2'b01, 24'h0,      24'h0,      24'd4608,   1'b1, 1'b0};
        tbl[2] = '{2'b10, 24'h0,      24'd57600,  24'd57600,  1'b1, 1'b0};
        tbl[3] = '{2'b10, 24'h0,      24'd57601,  24'd57600,  1'b0, 1'b0};
        tbl[4] = '{2'b00, 24'hFFFFFF, 24'h0,      24'hFFFFFF, 1'b1, 1'b1};
        tbl[5] = '{2'b00, 24'hFFFBFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0};
        tbl[6] = '{2'b00, 24'hFFFC00, 24'h0,      24'hFFFFFF, 1'b1, 1'b1};
        tbl[7] = '{2'b01, 24'h000100, 24'd5000,   24'd4864,   1'b0, 1'b0};

        // reset
        idle();
        RESETn = 1'b0;
        for (int s = 0; s < SEC; s++) feat_m[s] = '0;
        repeat (2) @(posedge RCK);
        #1;
        check_reset_outputs("reset_state");
        RESETn = 1'b1;

        // fill kernel and features with all ones
        for (int i = 0; i < ROWS * SEC; i++) begin
            write_word(i, '1, '1);
            if (i < SEC) begin
                FCSN = 1'b0; FA = FAW'(i); FD = '1;
            end
            tick();
        end

        // memory mode: full write, masked write, same-edge collision
        write_word(0, {(W/8){8'hA5}}, '1); tick();
        RCSN = 1'b0; RA = '0; tick();
        n_cmp++;
        if (Q !== {(W/8){8'hA5}}) fail_line("q_a5", Q, {(W/8){8'hA5}});
        write_word(1, '0, W'(4'hF)); tick();
        RCSN = 1'b0; RA = AW'(1); tick();
        n_cmp++;
        if (Q !== {{(W-4){1'b1}}, 4'h0}) fail_line("q_mask", Q, {{(W-4){1'b1}}, 4'h0});
        write_word(2, '0, '1); RCSN = 1'b0; RA = AW'(2); tick();
        n_cmp++;
        if (Q !== {W{1'b1}}) fail_line("q_collision", Q, {W{1'b1}});
        RCSN = 1'b0; RA = AW'(2); tick();
        for (int i = 0; i < 3; i++) begin
            write_word(i, '1, '1); tick();
        end

        // vector table, issued back to back on row 0
        tbl_on = 1;
        for (int i = 0; i < 8; i++) begin
            tbl_exp = {tbl[i].ps, tbl[i].so, tbl[i].ov};
            mac_req(0, tbl[i].mode, tbl[i].addin, tbl[i].thr);
            tick();
        end
        tbl_on = 0;
        repeat (LAT + 2) tick();

        // pipeline: rows 0..4 mixed modes, with a reserved-mode and an unselected request inserted
        for (int r = 1; r < 5; r++) begin
            for (int s = 0; s < SEC; s++) begin
                write_word(r * SEC + s, rand_w(), '1); tick();
            end
        end
        mac_req(0, 2'b00, 24'd3, 24'd500);   tick();
        mac_req(1, 2'b10, 24'd0, 24'd20000); tick();
        mac_req(2, 2'b00, 24'd7, 24'd0);     tick();
        mac_req(2, 2'b11, 24'd0, 24'd0);     tick();
        mac_req(3, 2'b10, 24'd0, 24'd30000); tick();
        mac_req(3, 2'b00, 24'd0, 24'd0); RCSN = 1'b1; tick();
        mac_req(4, 2'b01, 24'd1, 24'd2000);  tick();
        repeat (LAT + 2) tick();

        // hazard: kernel write to row 0 on the same edge as a MAC of row 0
        write_word(0, '0, '1); mac_req(0, 2'b00, 24'd0, 24'd0); tick();
        mac_req(0, 2'b00, 24'd0, 24'd0); tick();
        repeat (LAT + 2) tick();

        // reset two cycles after a request: its result must never appear
        mac_req(1, 2'b10, 24'd0, 24'd0); tick();
        tick();
        tick();
        RESETn = 1'b0;
        exp_q.delete();
        exp_t.delete();
        for (int s = 0; s < SEC; s++) feat_m[s] = '0;
        #1;
        check_reset_outputs("reset_mid_pipe");
        tick();
        RESETn = 1'b1;
        repeat (LAT + 2) tick();

        // random traffic
        for (int s = 0; s < SEC; s++) begin
            FCSN = 1'b0; FA = FAW'(s); FD = rand_w(); tick();
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                write_word(int'($urandom_range(0, ROWS * SEC - 1)), rand_w(), rand_w());
            end
            if ($urandom_range(0, 7) == 0) begin
                FCSN = 1'b0; FA = FAW'($urandom_range(0, SEC - 1)); FD = rand_w();
            end
            RCSN  = ($urandom_range(0, 3) == 0);
            COMPE = 1'($urandom_range(0, 1));
            MODE  = 2'($urandom_range(0, 3));
            RA    = AW'($urandom_range(0, ROWS * SEC - 1));
            ADDIN = ($urandom_range(0, 7) == 0) ? ACC_W'(24'hFFFFFF - $urandom_range(0, 3000))
                                               : ACC_W'($urandom_range(0, 1000));
            THR   = ACC_W'($urandom_range(0, 60000));
            tick();
        end
        repeat (LAT + 2) tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
